// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding, sequencer state encoding and default
// per-operation latencies for the ALU command sequencer.
package alu_pkg;

  // ALU operation codes as seen on cmd_op / alu_operation
  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    MULT = 2'b10,
    DIV  = 2'b11
  } alu_op_t;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    RESP = 2'b10
  } seq_state_t;

  // Default number of cycles ENABLE is held per operation class
  localparam int DEFAULT_ADDSUB_LAT = 1;
  localparam int DEFAULT_MULT_LAT   = 8;
  localparam int DEFAULT_DIV_LAT    = 8;

  // A latency of zero makes no sense for a held-enable protocol; clamp to 1
  function automatic int effective_lat(input int lat);
    return (lat < 1) ? 1 : lat;
  endfunction

  // Largest of three latencies, used to size the latency counter
  function automatic int max_lat(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/alu_seq_lat_counter.sv
// alu_seq_lat_counter: loadable down-counter with a zero flag. It stops at
// zero rather than wrapping, so it can sit at zero until the next load.
module alu_seq_lat_counter
  import alu_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count_reg;

  // Load has priority over decrement; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts one command at a time, drives the ALU operand
// pins with ENABLE held for the operation's latency, then captures the ALU
// outputs into a valid/ready response register.
// Optional feature macro: ALU_SEQ_DIV0_TRAP_EN -- a DIV with cmd_b==0 is
// not issued to the ALU; an all-zero response with rsp_err=1 is returned.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDSUB_LAT = DEFAULT_ADDSUB_LAT,
  parameter int MULT_LAT   = DEFAULT_MULT_LAT,
  parameter int DIV_LAT    = DEFAULT_DIV_LAT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [1:0]       alu_operation,
  output logic             ENABLE,
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] result2,
  input  logic [3:0]       flags,
  input  logic             carry_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_result2,
  output logic [3:0]       rsp_flags,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             busy
);

  localparam int ADDSUB_EFF = effective_lat(ADDSUB_LAT);
  localparam int MULT_EFF   = effective_lat(MULT_LAT);
  localparam int DIV_EFF    = effective_lat(DIV_LAT);
  localparam int MAX_LAT    = max_lat(ADDSUB_EFF, MULT_EFF, DIV_EFF);
  localparam int CW         = $clog2(MAX_LAT + 1);

  seq_state_t    state_reg;
  seq_state_t    state_next;
  logic          accept;
  logic          div0_trap;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;
  logic [CW-1:0] lat_load;

  assign accept = cmd_valid && cmd_ready;

`ifdef ALU_SEQ_DIV0_TRAP_EN
  assign div0_trap = (cmd_op == DIV) && (cmd_b == '0);
`else
  assign div0_trap = 1'b0;
`endif

  // Counter preload: the counter hits zero on the last enabled cycle
  always_comb begin
    lat_load = CW'(ADDSUB_EFF - 1);
    case (cmd_op)
      MULT:    lat_load = CW'(MULT_EFF - 1);
      DIV:     lat_load = CW'(DIV_EFF - 1);
      default: lat_load = CW'(ADDSUB_EFF - 1);
    endcase
  end

  alu_seq_lat_counter #(
    .CW(CW)
  ) u_lat_counter (
    .clk       (CLK),
    .rst_n     (RESET),
    .load      (cnt_load),
    .load_value(lat_load),
    .dec       (cnt_dec),
    .zero      (cnt_zero)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. RUN has two phases told apart by ENABLE: the enabled
  // phase lasts the full latency, then one ENABLE-low cycle lets the ALU's
  // registered outputs settle before they are captured.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = div0_trap ? RESP : RUN;
        end
      end
      RUN: begin
        if (!ENABLE) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs and counter controls
  always_comb begin
    cmd_ready = (state_reg == IDLE);
    busy      = (state_reg != IDLE);
    cnt_load  = (state_reg == IDLE) && accept;
    cnt_dec   = (state_reg == RUN);
  end

  // ALU pin drivers and response register. Operands stay on the pins after
  // ENABLE drops; only ENABLE qualifies them.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      operand_a     <= '0;
      operand_b     <= '0;
      alu_operation <= '0;
      ENABLE        <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_result2   <= '0;
      rsp_flags     <= '0;
      rsp_carry     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            operand_a     <= cmd_a;
            operand_b     <= cmd_b;
            alu_operation <= cmd_op;
            if (div0_trap) begin
              rsp_valid   <= 1'b1;
              rsp_result  <= '0;
              rsp_result2 <= '0;
              rsp_flags   <= '0;
              rsp_carry   <= 1'b0;
            end else begin
              ENABLE <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ENABLE) begin
            if (cnt_zero) begin
              ENABLE <= 1'b0;
            end
          end else begin
            rsp_valid   <= 1'b1;
            rsp_result  <= result;
            rsp_result2 <= result2;
            rsp_flags   <= flags;
            rsp_carry   <= carry_out;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_DIV0_TRAP_EN
  logic rsp_err_reg;

  // Error flag is set only by a trapped divide and cleared by any ALU capture
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rsp_err_reg <= 1'b0;
    end else if ((state_reg == IDLE) && accept && div0_trap) begin
      rsp_err_reg <= 1'b1;
    end else if ((state_reg == RUN) && !ENABLE) begin
      rsp_err_reg <= 1'b0;
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
